conv_dataflow_sequencer: RTL and testbench
==========================================

CONV_DATAFLOW_SEQUENCER -- requirements
Module: conv_dataflow_sequencer

Interface
REQ-001 SHALL have parameter K_PEGroupSize, default 4, weight PEs per group.
REQ-002 SHALL have parameter O_PEGroupSize, default 4, output PEs per group.
REQ-003 SHALL have parameter I_PEGroupSize, default K_PEGroupSize+O_PEGroupSize-1, input beats per block.
REQ-004 SHALL have parameter BlockCount, default 4, blocks per job.
REQ-005 SHALL have parameter BlockCountWidth, default 3, block counter width.
REQ-006 SHALL have parameter O_Latency, default 2, cycles from EN_O_In to matching EN_O_Out (>=1).
REQ-007 SHALL have port clk, input, 1, sole clock; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port aclr_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port sclr, input, 1, synchronous clear, active-high.
REQ-010 SHALL have port start, input, 1, job request, sampled in IDLE only.
REQ-011 SHALL have port in_valid, input, 1, upstream buffer holds a weight/input word this cycle.
REQ-012 SHALL have port out_ready, input, 1, output buffer can accept a result this cycle.
REQ-013 SHALL have ports busy and done, output, 1 each: job active; one-cycle completion pulse.
REQ-014 SHALL have ports EN_K, EN_I, EN_O_In, EN_O_Out, output, 1 each: strobes to the PE address controller.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_K, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 -> LOAD_K next cycle; busy=0 only in IDLE and DONE.
REQ-017 LOAD_K: EN_K=in_valid; after K_PEGroupSize accepted beats -> RUN.
REQ-018 RUN: EN_I=in_valid & ~freeze; beat counter 0..I_PEGroupSize-1 advances on EN_I, wraps to 0 and increments block counter.
REQ-019 EN_O_In SHALL equal EN_I when beat index >= K_PEGroupSize-1 (O_PEGroupSize pulses per block).
REQ-020 EN_O_In SHALL enter an O_Latency-deep delay line; EN_O_Out = head & out_ready.
REQ-021 freeze = head & ~out_ready; while frozen, the delay line holds and EN_I, EN_O_In are 0.
REQ-022 out_ready=0 with head=0 SHALL not freeze.
REQ-023 Last beat of block BlockCount-1 -> DRAIN; DRAIN -> DONE once delay line empty.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 in_valid=0 mid-block: no strobe, all counters hold.
REQ-026 start while busy SHALL be ignored.

Reset
REQ-027 aclr_n=0 SHALL immediately force IDLE, all counters and delay line 0, all outputs 0.
REQ-028 sclr=1 SHALL do the same at the clock edge, has priority over start, and aborts a job mid-operation without a done pulse.

Configuration
REQ-029 With CONV_SEQ_STALL_CNT_EN defined: output stall_cnt [15:0], counting freeze cycles, saturating at 16'hFFFF, cleared on accepted start and on reset.
REQ-030 Without CONV_SEQ_STALL_CNT_EN: port and counter absent; behaviour otherwise identical.

Structure
REQ-031 Package conv_pkg SHALL hold the FSM state enum and default group-size/BlockCount constants.
REQ-032 The O_Latency delay line SHALL be sub-module seq_delay_line (stallable shift register); counters stay inline.

Verification
REQ-033 Defaults, in_valid=1, out_ready=1, start pulse at cycle 0 -> EN_K cycles 1-4, EN_I 28 pulses cycles 5-32, EN_O_In 16, EN_O_Out 16, done=1 at cycle 35.
REQ-034 out_ready=0 for 5 cycles when delay-line head set -> EN_I/EN_O_In 0 for those 5 cycles, totals unchanged, done delayed 5 cycles, stall_cnt=5 (macro on).
REQ-035 in_valid toggling 1/0 every cycle -> EN_K/EN_I only on in_valid=1 cycles, totals 4/28/16/16.
REQ-036 sclr during block 2 -> next cycle IDLE, busy=0, no done; new start runs full job with correct totals.
REQ-037 aclr_n low during DRAIN -> outputs 0 immediately; start while busy -> no effect on counts.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared FSM state type and default PE-group geometry for the convolution
// dataflow sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int unsigned DEF_K_PE_GROUP  = 4;
  localparam int unsigned DEF_O_PE_GROUP  = 4;
  localparam int unsigned DEF_BLOCK_COUNT = 4;

endpackage

// File: rtl/seq_delay_line.sv
// Stallable shift register carrying EN_O_In tokens to the output side.
// head is the oldest stage; tail_busy reports any token behind it.
module seq_delay_line #(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic aclr_n,
  input  logic sclr,
  input  logic hold,
  input  logic din,
  output logic head,
  output logic tail_busy
);

  logic [Depth-1:0] sr;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      sr <= '0;
    end else if (sclr) begin
      sr <= '0;
    end else if (!hold) begin
      sr[0] <= din;
      for (int unsigned i = 1; i < Depth; i++) sr[i] <= sr[i-1];
    end
  end

  assign head = sr[Depth-1];

  always_comb begin
    tail_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < Depth; i++) tail_busy = tail_busy | sr[i];
  end

endmodule

// File: rtl/conv_dataflow_sequencer.sv
// Sequences weight load, input streaming and output collection for one
// convolution job. Optional freeze counter: define CONV_SEQ_STALL_CNT_EN.
module conv_dataflow_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned K_PEGroupSize   = DEF_K_PE_GROUP,
  parameter int unsigned O_PEGroupSize   = DEF_O_PE_GROUP,
  parameter int unsigned I_PEGroupSize   = K_PEGroupSize + O_PEGroupSize - 1,
  parameter int unsigned BlockCount      = DEF_BLOCK_COUNT,
  parameter int unsigned BlockCountWidth = 3,
  parameter int unsigned O_Latency       = 2
) (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        sclr,
  input  logic        start,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        EN_K,
  output logic        EN_I,
  output logic        EN_O_In,
  output logic        EN_O_Out
`ifdef CONV_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned BeatWidth = (I_PEGroupSize > 1) ? $clog2(I_PEGroupSize) : 1;
  localparam logic [BeatWidth-1:0]       LastKBeat = BeatWidth'(K_PEGroupSize - 1);
  localparam logic [BeatWidth-1:0]       LastIBeat = BeatWidth'(I_PEGroupSize - 1);
  localparam logic [BlockCountWidth-1:0] LastBlock = BlockCountWidth'(BlockCount - 1);

  seq_state_e                 state;
  logic [BeatWidth-1:0]       beat;
  logic [BlockCountWidth-1:0] block;
  logic                       head;
  logic                       tail_busy;
  logic                       freeze;

  // A result waiting at the head with nowhere to go stalls the whole stream.
  assign freeze   = head & ~out_ready;
  assign busy     = (state == LOAD_K) | (state == RUN) | (state == DRAIN);
  assign done     = (state == DONE);
  assign EN_K     = (state == LOAD_K) & in_valid;
  assign EN_I     = (state == RUN) & in_valid & ~freeze;
  assign EN_O_In  = EN_I & (beat >= LastKBeat);
  assign EN_O_Out = head & out_ready;

  seq_delay_line #(
    .Depth(O_Latency)
  ) u_delay (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .sclr     (sclr),
    .hold     (freeze),
    .din      (EN_O_In),
    .head     (head),
    .tail_busy(tail_busy)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= IDLE;
      beat  <= '0;
      block <= '0;
    end else if (sclr) begin
      state <= IDLE;
      beat  <= '0;
      block <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD_K;
          beat  <= '0;
          block <= '0;
        end
        LOAD_K: if (in_valid) begin
          if (beat == LastKBeat) begin
            beat  <= '0;
            state <= RUN;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        RUN: if (EN_I) begin
          if (beat == LastIBeat) begin
            beat <= '0;
            if (block == LastBlock) state <= DRAIN;
            else                    block <= block + 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        // Leave once the head is gone this cycle and nothing follows it.
        DRAIN: if (!freeze && !tail_busy) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      stall_cnt <= '0;
    end else if (sclr || (state == IDLE && start)) begin
      stall_cnt <= '0;
    end else if (freeze && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_dataflow_sequencer.sv
// Randomised and directed bench for conv_dataflow_sequencer against a
// token/queue reference model.
module tb_conv_dataflow_sequencer;

  localparam int K = 4;
  localparam int O = 4;
  localparam int I = K + O - 1;
  localparam int NB = 4;
  localparam int L = 2;
  localparam int N = I * NB;

  logic clk = 1'b0;
  logic aclr_n, sclr, start, in_valid, out_ready;
  logic busy, done, EN_K, EN_I, EN_O_In, EN_O_Out;
`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_dataflow_sequencer #(
    .K_PEGroupSize  (K),
    .O_PEGroupSize  (O),
    .I_PEGroupSize  (I),
    .BlockCount     (NB),
    .BlockCountWidth(3),
    .O_Latency      (L)
  ) dut (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .sclr     (sclr),
    .start    (start),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .EN_K     (EN_K),
    .EN_I     (EN_I),
    .EN_O_In  (EN_O_In),
    .EN_O_Out (EN_O_Out)
`ifdef CONV_SEQ_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // Reference model: job phase plus counts of accepted weight/input beats,
  // and a queue of in-flight output tokens (front = oldest).
  typedef enum {M_IDLE, M_ACTIVE, M_FINISH} mphase_e;
  mphase_e ph;
  int k_acc, i_acc, stalls;
  bit pipe[$];

  int cyc;
  int n_k, n_i, n_oi, n_oo, n_done, n_bad_valid;
  int first_k, last_k, first_i, last_i, done_cyc;

  function automatic void model_clear();
    ph = M_IDLE;
    k_acc = 0;
    i_acc = 0;
    stalls = 0;
    pipe.delete();
    for (int i = 0; i < L; i++) pipe.push_back(1'b0);
  endfunction

  function automatic void clear_tally();
    cyc = 0;
    n_k = 0; n_i = 0; n_oi = 0; n_oo = 0; n_done = 0; n_bad_valid = 0;
    first_k = -1; last_k = -1; first_i = -1; last_i = -1; done_cyc = -1;
  endfunction

  function automatic bit model_draining();
    return (ph == M_ACTIVE) && (k_acc == K) && (i_acc == N);
  endfunction

  task automatic step(input string tag);
    bit frz, ek, ei, eoi, eoo, eb, ed, was_drain, any;
    @(negedge clk);
    frz = pipe[0] && !out_ready;
    ek  = (ph == M_ACTIVE) && (k_acc < K) && in_valid;
    ei  = (ph == M_ACTIVE) && (k_acc == K) && (i_acc < N) && in_valid && !frz;
    eoi = ei && ((i_acc % I) >= K - 1);
    eoo = pipe[0] && out_ready;
    eb  = (ph == M_ACTIVE);
    ed  = (ph == M_FINISH);
    checks++;
    if ({busy, done, EN_K, EN_I, EN_O_In, EN_O_Out} !== {eb, ed, ek, ei, eoi, eoo}) begin
      errors++;
      $display("FAIL %s cyc=%0d busy/done/K/I/OIn/OOut got=%b want=%b", tag, cyc,
               {busy, done, EN_K, EN_I, EN_O_In, EN_O_Out}, {eb, ed, ek, ei, eoi, eoo});
    end
`ifdef CONV_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(stalls)) begin
      errors++;
      $display("FAIL %s_stall cyc=%0d stall_cnt got=%0d want=%0d", tag, cyc, stall_cnt, stalls);
    end
`endif
    if (EN_K) begin n_k++; if (first_k < 0) first_k = cyc; last_k = cyc; end
    if (EN_I) begin n_i++; if (first_i < 0) first_i = cyc; last_i = cyc; end
    if (EN_O_In) n_oi++;
    if (EN_O_Out) n_oo++;
    if (done) begin n_done++; done_cyc = cyc; end
    if ((EN_K || EN_I) && !in_valid) n_bad_valid++;

    if (sclr) begin
      model_clear();
    end else begin
      case (ph)
        M_IDLE: if (start) begin
          ph = M_ACTIVE; k_acc = 0; i_acc = 0; stalls = 0;
        end
        M_ACTIVE: begin
          was_drain = model_draining();
          if (frz) begin
            if (stalls < 65535) stalls++;
          end else begin
            void'(pipe.pop_front());
            pipe.push_back(eoi);
          end
          if (ek) k_acc++;
          if (ei) i_acc++;
          any = 1'b0;
          foreach (pipe[j]) any |= pipe[j];
          if (was_drain && !any) ph = M_FINISH;
        end
        default: ph = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to_done(input string tag);
    for (int n = 0; n < 300 && done_cyc < 0; n++) step(tag);
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL %s_timeout done got=none want=pulse", tag);
    end
    step(tag);
  endtask

  task automatic check_totals(input string tag);
    checks++;
    if ({n_k, n_i, n_oi, n_oo} !== {32'd4, 32'd28, 32'd16, 32'd16}) begin
      errors++;
      $display("FAIL %s_totals K/I/OIn/OOut got=%0d/%0d/%0d/%0d want=4/28/16/16",
               tag, n_k, n_i, n_oi, n_oo);
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL %s_done_count got=%0d want=1", tag, n_done);
    end
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; sclr = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #2;
    checks++;
    if ({busy, done, EN_K, EN_I, EN_O_In, EN_O_Out} !== 6'b0) begin
      errors++;
      $display("FAIL reset outputs got=%b want=000000", {busy, done, EN_K, EN_I, EN_O_In, EN_O_Out});
    end
`ifdef CONV_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall got=%0d want=0", stall_cnt);
    end
`endif
    @(negedge clk);
    aclr_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    clear_tally();
    for (int n = 0; n < 3; n++) step("reset_idle");
  endtask

  task automatic test_nominal();
    clear_tally();
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    step("nominal");
    start = 1'b0;
    run_to_done("nominal");
    check_totals("nominal");
    checks++;
    if ({first_k, last_k} !== {32'd1, 32'd4}) begin
      errors++;
      $display("FAIL nominal_k_window got=%0d..%0d want=1..4", first_k, last_k);
    end
    checks++;
    if ({first_i, last_i} !== {32'd5, 32'd32}) begin
      errors++;
      $display("FAIL nominal_i_window got=%0d..%0d want=5..32", first_i, last_i);
    end
    checks++;
    if (done_cyc !== 35) begin
      errors++;
      $display("FAIL nominal_done_cycle got=%0d want=35", done_cyc);
    end
  endtask

  task automatic test_stall();
    int left;
    bit used;
    clear_tally();
    left = 0; used = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    step("stall");
    start = 1'b0;
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      if (!used && pipe[0]) begin used = 1'b1; left = 5; end
      out_ready = (left == 0);
      if (left > 0) left--;
      step("stall");
    end
    out_ready = 1'b1;
    checks++;
    if (done_cyc !== 40) begin
      errors++;
      $display("FAIL stall_done_cycle got=%0d want=40", done_cyc);
    end
    step("stall");
    check_totals("stall");
`ifdef CONV_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_cnt_final got=%0d want=5", stall_cnt);
    end
`endif
  endtask

  task automatic test_valid_toggle();
    clear_tally();
    out_ready = 1'b1; in_valid = 1'b1; start = 1'b1;
    step("toggle");
    start = 1'b0;
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      in_valid = ~in_valid;
      step("toggle");
    end
    in_valid = 1'b1;
    step("toggle");
    check_totals("toggle");
    checks++;
    if (n_bad_valid !== 0) begin
      errors++;
      $display("FAIL toggle_strobe_without_valid got=%0d want=0", n_bad_valid);
    end
  endtask

  task automatic test_sclr_abort();
    clear_tally();
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    step("sclr");
    start = 1'b0;
    for (int n = 0; n < 100 && i_acc < 2 * I + 3; n++) step("sclr");
    sclr = 1'b1; start = 1'b1;
    step("sclr");
    sclr = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sclr_busy got=%b want=0", busy);
    end
    for (int n = 0; n < 6; n++) step("sclr_idle");
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL sclr_no_done got=%0d want=0", n_done);
    end
    clear_tally();
    start = 1'b1;
    step("sclr_rerun");
    start = 1'b0;
    run_to_done("sclr_rerun");
    check_totals("sclr_rerun");
  endtask

  task automatic test_aclr_drain();
    clear_tally();
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    step("aclr");
    start = 1'b0;
    for (int n = 0; n < 300 && !model_draining(); n++) begin
      start = (n % 3 == 0);
      step("aclr");
    end
    start = 1'b0;
    checks++;
    if ({n_k, n_i} !== {32'd4, 32'd28}) begin
      errors++;
      $display("FAIL busy_start_totals K/I got=%0d/%0d want=4/28", n_k, n_i);
    end
    #2;
    aclr_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, EN_K, EN_I, EN_O_In, EN_O_Out} !== 6'b0) begin
      errors++;
      $display("FAIL aclr_drain outputs got=%b want=000000", {busy, done, EN_K, EN_I, EN_O_In, EN_O_Out});
    end
    @(negedge clk);
    aclr_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    clear_tally();
    for (int n = 0; n < 3; n++) step("aclr_idle");
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL aclr_no_done got=%0d want=0", n_done);
    end
  endtask

  task automatic test_random();
    clear_tally();
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 7) == 0);
      sclr      = ($urandom_range(0, 299) == 0);
      step("random");
    end
    sclr = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 80; n++) step("random_tail");
    checks++;
    if (n_done < 3) begin
      errors++;
      $display("FAIL random_jobs_completed got=%0d want>=3", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_valid_toggle();
    test_sclr_abort();
    test_aclr_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
